// File: rtl/wb_master_if_if.sv
// Wishbone B4 classic bus bundle between the single-transfer master and a slave.
interface wb_master_if_if #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32
);
    logic                              wb_cyc_o;
    logic                              wb_stb_o;
    logic                              wb_we_o;
    logic [WISHBONE_ADDR_WIDTH-1:0]    wb_adr_o;
    logic [WISHBONE_BUS_WIDTH-1:0]     wb_dat_o;
    logic [WISHBONE_BUS_WIDTH/8-1:0]   wb_sel_o;
    logic [WISHBONE_BUS_WIDTH-1:0]     wb_dat_i;
    logic                              wb_ack_i;
    logic                              wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_master_if.sv
// Wishbone B4 classic single-transfer master for the memory stage.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_if #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_req_i,
    input  logic                              wen_i,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]    adr_i,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     wdata_i,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]   sel_i,
    output logic [WISHBONE_BUS_WIDTH-1:0]     rdata_o,
    output logic                              done_req_o,
    output logic                              err_o,
    wb_master_if_if.master                    wb
);
    localparam int SW = WISHBONE_BUS_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                           state_q, state_d;
    logic                             cyc_q, cyc_d;
    logic                             we_q, we_d;
    logic [WISHBONE_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WISHBONE_BUS_WIDTH-1:0]    dat_q, dat_d;
    logic [SW-1:0]                    sel_q, sel_d;
    logic [WISHBONE_BUS_WIDTH-1:0]    rdata_q, rdata_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]                      cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_req_i) begin
                    state_d = BUSY;
                    cyc_d   = 1'b1;
                    we_d    = wen_i;
                    adr_d   = adr_i;
                    dat_d   = wdata_i;
                    sel_d   = wen_i ? sel_i : '1;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (wb.wb_ack_i || wb.wb_err_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    // err wins over a simultaneous ack: read data is not trusted
                    err_d   = wb.wb_err_i;
                    if (!wb.wb_err_i && !we_q)
                        rdata_d = wb.wb_dat_i;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset drops cyc/stb immediately, abandoning any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign rdata_o     = rdata_q;
    assign done_req_o  = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_wb_master_if.sv
// Directed bench for wb_master_if: loads, stores, errors, spurious start, reset abort, timeout.
module tb_wb_master_if;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_req_i = 1'b0;
    logic        wen_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] rdata_o;
    logic        done_req_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int base;

    wb_master_if_if #(.WISHBONE_ADDR_WIDTH(32), .WISHBONE_BUS_WIDTH(32)) bus ();

    wb_master_if #(
        .WISHBONE_ADDR_WIDTH(32),
        .WISHBONE_BUS_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_req_i(start_req_i), .wen_i(wen_i), .adr_i(adr_i),
        .wdata_i(wdata_i), .sel_i(sel_i),
        .rdata_o(rdata_o), .done_req_o(done_req_o), .err_o(err_o),
        .wb(bus)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_req_o) done_cnt++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        start_req_i = 1'b1; wen_i = we; adr_i = a; wdata_i = d; sel_i = s;
        tick();
        start_req_i = 1'b0;
    endtask

    task automatic slave(input logic ack, input logic err, input logic [31:0] d);
        bus.wb_ack_i = ack; bus.wb_err_i = err; bus.wb_dat_i = d;
    endtask

    initial begin
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("rst_cyc", bus.wb_cyc_o, 0);
        check("rst_stb", bus.wb_stb_o, 0);
        check("rst_we", bus.wb_we_o, 0);
        check("rst_adr", bus.wb_adr_o, 0);
        check("rst_sel", bus.wb_sel_o, 0);
        check("rst_done", done_req_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", rdata_o, 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // zero-wait load
        req(1'b0, 32'h1000, 32'h0, 4'h0);
        check("ld_stb", bus.wb_stb_o, 1);
        check("ld_cyc", bus.wb_cyc_o, 1);
        check("ld_we", bus.wb_we_o, 0);
        check("ld_adr", bus.wb_adr_o, 32'h1000);
        check("ld_sel", bus.wb_sel_o, 4'hF);
        check("ld_done_early", done_req_o, 0);
        slave(1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("ld_done", done_req_o, 1);
        check("ld_err", err_o, 0);
        check("ld_rdata", rdata_o, 32'hDEADBEEF);
        check("ld_cyc_off", bus.wb_cyc_o, 0);
        tick();
        check("ld_done_pulse", done_req_o, 0);

        // store with 3 wait states
        base = done_cnt;
        req(1'b1, 32'h2004, 32'h0000AB00, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            check("st_we", bus.wb_we_o, 1);
            check("st_stb", bus.wb_stb_o, 1);
            check("st_adr", bus.wb_adr_o, 32'h2004);
            check("st_dat", bus.wb_dat_o, 32'h0000AB00);
            check("st_sel", bus.wb_sel_o, 4'b0010);
            check("st_no_done", done_req_o, 0);
            tick();
        end
        slave(1'b1, 1'b0, 32'h55555555);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("st_done", done_req_o, 1);
        check("st_err", err_o, 0);
        check("st_rdata_keep", rdata_o, 32'hDEADBEEF);
        check("st_we_off", bus.wb_we_o, 0);
        tick();
        check("st_one_done", done_cnt - base, 1);

        // ack and err together on a load
        req(1'b0, 32'h3000, 32'h0, 4'h0);
        slave(1'b1, 1'b1, 32'h12345678);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("er_done", done_req_o, 1);
        check("er_err", err_o, 1);
        check("er_rdata_keep", rdata_o, 32'hDEADBEEF);
        check("er_cyc_off", bus.wb_cyc_o, 0);
        tick();
        check("er_err_pulse", err_o, 0);

        // spurious start while busy
        base = done_cnt;
        req(1'b0, 32'h4000, 32'h0, 4'h0);
        req(1'b1, 32'h5000, 32'h11111111, 4'h1);
        check("sp_adr", bus.wb_adr_o, 32'h4000);
        check("sp_we", bus.wb_we_o, 0);
        slave(1'b1, 1'b0, 32'hCAFEF00D);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("sp_done", done_req_o, 1);
        check("sp_rdata", rdata_o, 32'hCAFEF00D);
        tick(); tick();
        check("sp_no_cycle", bus.wb_cyc_o, 0);
        check("sp_one_done", done_cnt - base, 1);

        // reset mid-transfer
        base = done_cnt;
        req(1'b0, 32'h7000, 32'h0, 4'h0);
        check("rs_cyc_before", bus.wb_cyc_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rs_cyc_async", bus.wb_cyc_o, 0);
        check("rs_stb_async", bus.wb_stb_o, 0);
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        check("rs_no_done", done_cnt - base, 0);
        req(1'b0, 32'h6000, 32'h0, 4'h0);
        check("rs2_adr", bus.wb_adr_o, 32'h6000);
        slave(1'b1, 1'b0, 32'h0BADCAFE);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("rs2_done", done_req_o, 1);
        check("rs2_rdata", rdata_o, 32'h0BADCAFE);
        tick();

        // unresponsive slave
        base = done_cnt;
        req(1'b0, 32'h8000, 32'h0, 4'h0);
`ifdef WB_MASTER_TIMEOUT_EN
        tick(); tick(); tick();
        check("to_not_yet", done_req_o, 0);
        check("to_still_busy", bus.wb_cyc_o, 1);
        tick();
        check("to_done", done_req_o, 1);
        check("to_err", err_o, 1);
        check("to_cyc_off", bus.wb_cyc_o, 0);
        check("to_rdata_keep", rdata_o, 32'h0BADCAFE);
`else
        for (int i = 0; i < 1000; i++) tick();
        check("nto_busy", bus.wb_cyc_o, 1);
        check("nto_no_done", done_cnt - base, 0);
        slave(1'b1, 1'b0, 32'hA5A5A5A5);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        check("nto_done", done_req_o, 1);
        check("nto_rdata", rdata_o, 32'hA5A5A5A5);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_master_if.md
Name: wb_master_if

Overview:
- Wishbone B4 classic single-transfer master between the memory stage and the data bus.
- Consumes the memory stage's start pulse, write enable, address, write data and byte select. Runs one bus cycle per request.
- Returns read data plus a one-cycle done pulse, which the memory stage uses as its read data and done inputs.
- Also reports bus errors; the memory stage does not consume err_o yet (a later trap path will).

Parameters:
- WISHBONE_ADDR_WIDTH, 32, address width of request and bus.
- WISHBONE_BUS_WIDTH, 32, data width; byte select width is WISHBONE_BUS_WIDTH/8.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before forced termination. Used only with the optional feature. Legal range 1..65535.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
- start_req_i  input  1  single-cycle request pulse from the memory stage.
- wen_i  input  1  1 = store, 0 = load; sampled with start_req_i.
- adr_i  input  WISHBONE_ADDR_WIDTH  byte address; sampled with start_req_i.
- wdata_i  input  WISHBONE_BUS_WIDTH  store data, already lane-aligned.
- sel_i  input  WISHBONE_BUS_WIDTH/8  store byte mask; ignored for loads.
- rdata_o  output  WISHBONE_BUS_WIDTH  captured read data.
- done_req_o  output  1  one-cycle completion pulse.
- err_o  output  1  high with done_req_o when the transfer ended in error.
- wb_cyc_o  output  1  bus cycle.
- wb_stb_o  output  1  strobe.
- wb_we_o  output  1  write enable.
- wb_adr_o  output  WISHBONE_ADDR_WIDTH  bus address.
- wb_dat_o  output  WISHBONE_BUS_WIDTH  bus write data.
- wb_sel_o  output  WISHBONE_BUS_WIDTH/8  bus byte select.
- wb_dat_i  input  WISHBONE_BUS_WIDTH  bus read data.
- wb_ack_i  input  1  slave acknowledge.
- wb_err_i  input  1  slave error.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; timeout counter 0.
- Asserting rst_ni low mid-transfer drops wb_cyc_o and wb_stb_o immediately (asynchronously). No done_req_o is produced for the aborted transfer.
- States: IDLE, BUSY.
- IDLE with start_req_i=1:
  - latch request; next edge enters BUSY;
  - wb_cyc_o=wb_stb_o=1; wb_we_o=wen_i; wb_adr_o=adr_i; wb_dat_o=wdata_i;
  - wb_sel_o=sel_i for stores, all ones for loads.
  - Bus strobe appears exactly 1 cycle after the start pulse.
- BUSY: cyc, stb, we, adr, dat and sel stay stable until termination. start_req_i is ignored (no queueing).
- BUSY with wb_ack_i=1 or wb_err_i=1 at an edge:
  - same edge: wb_cyc_o=wb_stb_o=0, wb_we_o=0, return to IDLE;
  - done_req_o=1 for exactly that one following cycle;
  - err_o=wb_err_i;
  - rdata_o<=wb_dat_i on a load ack; unchanged on store or error.
- ack and err together: treated as error (err_o=1, rdata_o not updated).
- Latency: a zero-wait-state slave (ack in the first stb cycle) gives done_req_o 2 cycles after start_req_i.
- rdata_o holds its value until the next successful load completes.
- start_req_i in the same cycle done_req_o is high: accepted (state is IDLE). Back-to-back transfers need a minimum of 2 cycles each.
- wb_adr_o is not realigned; the memory stage guarantees alignment.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - a 16-bit counter clears on IDLE->BUSY and increments each BUSY cycle without ack/err;
  - when the counter equals TIMEOUT_CYCLES-1 and no ack/err is present, the transfer terminates as an error (done_req_o=1, err_o=1, bus released);
  - an ack arriving in that same cycle wins.
- Not defined: no counter; BUSY waits indefinitely for ack/err.

Test Plan:
- Zero-wait load: start_req_i, adr_i=0x1000, wen_i=0; slave acks in first stb cycle with wb_dat_i=0xDEADBEEF -> stb 1 cycle after start, wb_sel_o=4'hF, done_req_o at cycle+2, rdata_o=0xDEADBEEF, err_o=0.
- Wait-state store: adr_i=0x2004, wdata_i=0x0000AB00, sel_i=4'b0010; ack after 3 wait cycles -> wb_we_o=1 and all bus outputs stable through the wait, single done pulse, rdata_o unchanged.
- Error termination: load with wb_err_i=1 and wb_ack_i=1 in the same cycle -> done_req_o=1, err_o=1, rdata_o retains its previous value.
- Spurious start: second start_req_i while BUSY -> ignored; exactly one bus cycle and one done pulse.
- Reset mid-transfer: rst_ni low while BUSY -> wb_cyc_o/wb_stb_o low before the next clock edge, no done pulse; a request issued after reset completes normally.
- Timeout (WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never responds -> done_req_o=1, err_o=1 after 4 BUSY cycles and bus released. Without the macro, BUSY persists for 1000 cycles.
